// File: rtl/produto_escalar_ctrl_pkg.sv
// rtl/produto_escalar_ctrl_pkg.sv - register map, bit indices and FSM states for the dot-product controller
package produto_escalar_pkg;

    localparam logic [4:0] ADDR_A0     = 5'h00;
    localparam logic [4:0] ADDR_B0     = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h11;
    localparam logic [4:0] ADDR_RES_LO = 5'h12;
    localparam logic [4:0] ADDR_RES_HI = 5'h13;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;
    localparam int STATUS_WR_ERR_BIT  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } ctrl_estado_t;

endpackage

// File: rtl/produto_escalar_ctrl_if.sv
// rtl/produto_escalar_ctrl_if.sv - CSR bus between the SoC and the dot-product controller
interface produto_escalar_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/produto_escalar_ctrl.sv
// rtl/produto_escalar_ctrl.sv - CSR register file, start/done FSM and timeout for the produto_escalar engine
module produto_escalar_ctrl
    import produto_escalar_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    produto_escalar_ctrl_if.slave csr,
    output logic                  irq,
    output logic [31:0]           a0,
    output logic [31:0]           a1,
    output logic [31:0]           a2,
    output logic [31:0]           a3,
    output logic [31:0]           a4,
    output logic [31:0]           a5,
    output logic [31:0]           a6,
    output logic [31:0]           a7,
    output logic [31:0]           b0,
    output logic [31:0]           b1,
    output logic [31:0]           b2,
    output logic [31:0]           b3,
    output logic [31:0]           b4,
    output logic [31:0]           b5,
    output logic [31:0]           b6,
    output logic [31:0]           b7,
    output logic                  iniciar,
    input  logic                  concluido,
    input  logic [63:0]           resultado
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    ctrl_estado_t state_q, state_d;

    logic [31:0] a_q [0:7];
    logic [31:0] a_d [0:7];
    logic [31:0] b_q [0:7];
    logic [31:0] b_d [0:7];
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        wr_err_q, wr_err_d;
    logic        normal_q, normal_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        busy;
    logic        wr_op, wr_ctrl, wr_status, start_req;
    logic        ev_launch, ev_capture, ev_timeout, ev_done;
    logic [31:0] rd_mux;
    logic [27:0] unused_wdata;

    assign unused_wdata = csr.wdata[31:4];

    assign wr_op     = csr.wr_en && !csr.addr[4];
    assign wr_ctrl   = csr.wr_en && (csr.addr == ADDR_CTRL);
    assign wr_status = csr.wr_en && (csr.addr == ADDR_STATUS);
    assign start_req = wr_ctrl && csr.wdata[CTRL_START_BIT];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_req) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (concluido || (cnt_q >= TMO_LAST)) state_d = RELEASE;
            RELEASE: if (!concluido) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // iniciar decodes straight from the state flop so an async reset drops it at once.
    always_comb begin
        busy       = (state_q != IDLE);
        iniciar    = (state_q == START) || (state_q == WAIT);
        ev_launch  = (state_q == IDLE) && start_req;
        ev_capture = (state_q == WAIT) && concluido;
        ev_timeout = (state_q == WAIT) && !concluido && (cnt_q >= TMO_LAST);
        ev_done    = (state_q == RELEASE) && !concluido && normal_q;
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        wr_err_d  = wr_err_q;
        normal_d  = normal_q;
        cnt_d     = cnt_q;
        res_d     = res_q;

        if (wr_op && !busy) begin
            if (csr.addr[3]) b_d[csr.addr[2:0]] = csr.wdata;
            else             a_d[csr.addr[2:0]] = csr.wdata;
        end
        if (wr_ctrl) irq_en_d = csr.wdata[CTRL_IRQ_EN_BIT];

        if (wr_status) begin
            if (csr.wdata[STATUS_DONE_BIT])    done_d    = 1'b0;
            if (csr.wdata[STATUS_TIMEOUT_BIT]) timeout_d = 1'b0;
            if (csr.wdata[STATUS_WR_ERR_BIT])  wr_err_d  = 1'b0;
        end
        if (ev_launch) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end

        // Hardware sets come last so they beat a W1C in the same cycle.
        if (ev_done)    done_d    = 1'b1;
        if (ev_timeout) timeout_d = 1'b1;
        if (busy && (wr_op || start_req)) wr_err_d = 1'b1;

        if (state_q == START)     cnt_d = '0;
        else if (state_q == WAIT) cnt_d = cnt_q + 16'd1;

        if (ev_capture) begin
            res_d    = resultado;
            normal_d = 1'b1;
        end
        if (ev_timeout) normal_d = 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        if (!csr.addr[4]) begin
            rd_mux = csr.addr[3] ? b_q[csr.addr[2:0]] : a_q[csr.addr[2:0]];
        end else begin
            unique case (csr.addr)
                ADDR_CTRL:   rd_mux = {30'd0, irq_en_q, 1'b0};
                ADDR_STATUS: rd_mux = {28'd0, wr_err_q, timeout_q, done_q, busy};
                ADDR_RES_LO: rd_mux = res_q[31:0];
                ADDR_RES_HI: rd_mux = res_q[63:32];
                default:     rd_mux = '0;
            endcase
        end
        rdata_d  = csr.rd_en ? rd_mux : rdata_q;
        rvalid_d = csr.rd_en;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_err_q  <= 1'b0;
            normal_q  <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wr_err_q  <= wr_err_d;
            normal_q  <= normal_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign csr.rdata  = rdata_q;
    assign csr.rvalid = rvalid_q;
    assign irq        = done_q & irq_en_q;

    assign a0 = a_q[0];
    assign a1 = a_q[1];
    assign a2 = a_q[2];
    assign a3 = a_q[3];
    assign a4 = a_q[4];
    assign a5 = a_q[5];
    assign a6 = a_q[6];
    assign a7 = a_q[7];
    assign b0 = b_q[0];
    assign b1 = b_q[1];
    assign b2 = b_q[2];
    assign b3 = b_q[3];
    assign b4 = b_q[4];
    assign b5 = b_q[5];
    assign b6 = b_q[6];
    assign b7 = b_q[7];

endmodule

// File: tb/tb_produto_escalar_ctrl.sv
// tb/tb_produto_escalar_ctrl.sv - scoreboard bench for produto_escalar_ctrl with a behavioural engine
module tb_produto_escalar_ctrl;
    import produto_escalar_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    produto_escalar_ctrl_if bus();

    logic        irq, iniciar, concluido;
    logic [63:0] resultado;
    logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7;

    produto_escalar_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .csr(bus), .irq(irq),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
        .iniciar(iniciar), .concluido(concluido), .resultado(resultado)
    );

    // Engine stand-in: 8 MAC cycles, holds concluido until iniciar drops.
    logic [31:0] av [0:7];
    logic [31:0] bv [0:7];
    logic        stub_hold = 1'b0;
    logic [3:0]  ecnt;
    always_comb begin
        av = '{a0, a1, a2, a3, a4, a5, a6, a7};
        bv = '{b0, b1, b2, b3, b4, b5, b6, b7};
    end

    function automatic logic [63:0] dot();
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            s = s + ({{32{av[i][31]}}, av[i]} * {{32{bv[i][31]}}, bv[i]});
        return s;
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            concluido <= 1'b0;
            ecnt      <= '0;
            resultado <= '0;
        end else if (!iniciar) begin
            concluido <= 1'b0;
            ecnt      <= '0;
        end else if (!concluido && !stub_hold) begin
            if (ecnt == 4'd7) begin
                concluido <= 1'b1;
                resultado <= dot();
            end else begin
                ecnt <= ecnt + 4'd1;
            end
        end
    end

    typedef struct { string name; logic [31:0] exp; } rd_exp_t;
    typedef struct { string name; logic [63:0] act; logic [63:0] exp; } pin_t;
    rd_exp_t rd_q [$];
    pin_t    pin_q [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit stim_done = 1'b0;

    always @(negedge clk_i) begin
        pin_t    p;
        rd_exp_t r;
        cyc++;
        while (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            total++;
            if (p.act !== p.exp) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", p.name, p.act, p.exp);
            end
        end
        if (bus.rvalid) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid: got rdata %0h expected no read", bus.rdata);
            end else begin
                r = rd_q.pop_front();
                if (bus.rdata !== r.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h", r.name, bus.rdata, r.exp);
                end
            end
        end
        if (stim_done || cyc > 60000) begin
            if (!stim_done) begin
                total++;
                bad++;
                $display("FAIL watchdog: got %0d cycles expected stimulus end", cyc);
            end
            while (rd_q.size() > 0) begin
                r = rd_q.pop_front();
                total++;
                bad++;
                $display("FAIL %s: got no rvalid expected %0h", r.name, r.exp);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        rd_q.push_back('{nm, e});
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic pin(input string nm, input logic [63:0] act, input logic [63:0] exp);
        pin_q.push_back('{nm, act, exp});
    endtask

    task automatic wait_irq(input string nm);
        int n = 0;
        while (!irq && n < 200) begin
            tick();
            n++;
        end
        pin(nm, {63'd0, irq}, 64'd1);
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) tick();
        pin("rst_iniciar", {63'd0, iniciar}, 64'd0);
        pin("rst_irq", {63'd0, irq}, 64'd0);
        pin("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        pin("rst_rdata", {32'd0, bus.rdata}, 64'd0);
        pin("rst_a0", {32'd0, a0}, 64'd0);
        rst_n = 1'b1;
        tick();

        rd(ADDR_A0, 32'd0, "rst_rd_a0");
        rd(ADDR_B0 + 5'd7, 32'd0, "rst_rd_b7");
        rd(ADDR_CTRL, 32'd0, "rst_rd_ctrl");
        rd(ADDR_STATUS, 32'd0, "rst_rd_status");
        rd(ADDR_RES_LO, 32'd0, "rst_rd_res_lo");
        wr(5'h1F, 32'hFFFF_FFFF);
        rd(5'h1F, 32'd0, "unmapped_rd");

        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = ADDR_A0 + 5'd1;
        bus.wdata = 32'h77;
        rd_q.push_back('{"wr_rd_pre_value", 32'd0});
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rd(ADDR_A0 + 5'd1, 32'h77, "wr_rd_post_value");

        for (int i = 0; i < 8; i++) begin
            wr(ADDR_A0 + 5'(i), 32'(i + 1));
            wr(ADDR_B0 + 5'(i), 32'(i + 1));
        end
        wr(ADDR_CTRL, 32'h3);
        pin("sq_iniciar_rise", {63'd0, iniciar}, 64'd1);
        rd(ADDR_STATUS, 32'h1, "sq_status_busy");
        rd(ADDR_CTRL, 32'h2, "sq_ctrl_rd");
        wait_irq("sq_irq");
        pin("sq_iniciar_low", {63'd0, iniciar}, 64'd0);
        rd(ADDR_STATUS, 32'h2, "sq_status_done");
        rd(ADDR_RES_LO, 32'h0000_00CC, "sq_res_lo");
        rd(ADDR_RES_HI, 32'h0, "sq_res_hi");
        rd(ADDR_A0 + 5'd3, 32'h4, "sq_a3");

        wr(ADDR_A0, 32'hFFFF_FFFF);
        wr(ADDR_B0, 32'h2);
        for (int i = 1; i < 8; i++) begin
            wr(ADDR_A0 + 5'(i), 32'd0);
            wr(ADDR_B0 + 5'(i), 32'd0);
        end
        wr(ADDR_CTRL, 32'h3);
        pin("sg_start_clears_irq", {63'd0, irq}, 64'd0);
        wait_irq("sg_irq");
        rd(ADDR_RES_LO, 32'hFFFF_FFFE, "sg_res_lo");
        rd(ADDR_RES_HI, 32'hFFFF_FFFF, "sg_res_hi");

        stub_hold = 1'b1;
        wr(ADDR_CTRL, 32'h3);
        n = 0;
        while (iniciar && n < 200) begin
            n++;
            tick();
        end
        pin("tmo_iniciar_cycles", 64'(n), 64'd65);
        tick();
        rd(ADDR_STATUS, 32'h4, "tmo_status");
        pin("tmo_irq", {63'd0, irq}, 64'd0);
        rd(ADDR_RES_LO, 32'hFFFF_FFFE, "tmo_res_lo_kept");
        rd(ADDR_RES_HI, 32'hFFFF_FFFF, "tmo_res_hi_kept");
        stub_hold = 1'b0;
        wr(ADDR_STATUS, 32'h4);

        wr(ADDR_CTRL, 32'h3);
        rises = 1;
        prev  = iniciar;
        wr(ADDR_A0 + 5'd3, 32'h55);
        if (iniciar && !prev) rises++;
        prev = iniciar;
        wr(ADDR_CTRL, 32'h3);
        n = 0;
        while (!irq && n < 200) begin
            if (iniciar && !prev) rises++;
            prev = iniciar;
            tick();
            n++;
        end
        if (iniciar && !prev) rises++;
        pin("busy_irq", {63'd0, irq}, 64'd1);
        pin("busy_one_rise", 64'(rises), 64'd1);
        rd(ADDR_A0 + 5'd3, 32'h0, "busy_a3_kept");
        rd(ADDR_STATUS, 32'hA, "busy_wr_err");
        wr(ADDR_STATUS, 32'hA);

        wr(ADDR_CTRL, 32'h3);
        n = 0;
        while (iniciar && n < 200) begin
            tick();
            n++;
        end
        while (concluido && n < 400) begin
            tick();
            n++;
        end
        pin("w1c_wait_bound", {63'd0, n < 400}, 64'd1);
        wr(ADDR_STATUS, 32'h2);
        pin("w1c_set_wins_irq", {63'd0, irq}, 64'd1);
        rd(ADDR_STATUS, 32'h2, "w1c_set_wins");
        wr(ADDR_STATUS, 32'h2);
        pin("w1c_irq_fall", {63'd0, irq}, 64'd0);
        rd(ADDR_STATUS, 32'h0, "w1c_cleared");

        wr(ADDR_CTRL, 32'h3);
        tick();
        tick();
        pin("pre_reset_iniciar", {63'd0, iniciar}, 64'd1);
        #1 rst_n = 1'b0;
        #1 pin("async_iniciar", {63'd0, iniciar}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pin("post_rst_irq", {63'd0, irq}, 64'd0);
        rd(ADDR_A0, 32'd0, "post_rst_a0");
        rd(ADDR_B0, 32'd0, "post_rst_b0");
        rd(ADDR_A0 + 5'd1, 32'd0, "post_rst_a1");
        rd(ADDR_CTRL, 32'd0, "post_rst_ctrl");
        rd(ADDR_STATUS, 32'd0, "post_rst_status");
        rd(ADDR_RES_LO, 32'd0, "post_rst_res_lo");
        rd(ADDR_RES_HI, 32'd0, "post_rst_res_hi");
        tick();
        tick();
        stim_done = 1'b1;
    end

endmodule
